// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings, FSM
// states and the request legality check used at accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD     = 3'd1,
    S_ST     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_DONE   = 3'd5
  } lsu_state_t;

  // A request faults on an encoding outside the RV32I set for its direction,
  // or on a half/word access that is not naturally aligned.
  function automatic logic req_fault(input logic       we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic legal;
    logic misaligned;
    if (we) begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return !legal || misaligned;
  endfunction

  function automatic logic is_subword_store(input logic [2:0] funct3);
    return (funct3 == F3_B) || (funct3 == F3_H);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: extracts and extends load data from a memory word, and
// merges a byte/half/word store into an existing word.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] ld_word_i,
  output logic [DATA_W-1:0] ld_data_o,
  input  logic [DATA_W-1:0] old_word_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] st_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = ld_word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel  = ld_word_i[{addr_lo_i[1], 4'b0000} +: 16];
    ld_data_o = '0;
    case (funct3_i)
      F3_B:    ld_data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_H:    ld_data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_HU:   ld_data_o = {{(DATA_W-16){1'b0}}, half_sel};
      F3_W:    ld_data_o = ld_word_i;
      default: ld_data_o = '0;
    endcase
  end

  // Only the addressed lane changes; every other byte of the old word survives.
  always_comb begin
    st_word_o = old_word_i;
    case (funct3_i)
      F3_B:    st_word_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
      F3_H:    st_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      F3_W:    st_word_o = wdata_i;
      default: st_word_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit: accepts one RV32I load/store at a time, issues word
// accesses to data memory (sub-word stores as read-modify-write) and responds.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;

  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_word;

  lsu_lane #(
    .DATA_W(DATA_W)
  ) u_lane (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .ld_word_i (mem_rdata),
    .ld_data_o (ld_data),
    .old_word_i(merge_q),
    .wdata_i   (wdata_q),
    .st_word_o (st_word)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_fault(req_we, req_funct3, req_addr[1:0])) begin
            state_d     = S_DONE;
            rsp_rdata_d = '0;
            rsp_fault_d = 1'b1;
          end else if (!req_we) begin
            state_d = S_LD;
          end else if (is_subword_store(req_funct3)) begin
            state_d = S_RMW_RD;
          end else begin
            state_d = S_ST;
          end
        end
      end
      S_LD: begin
        state_d     = S_DONE;
        rsp_rdata_d = ld_data;
        rsp_fault_d = 1'b0;
      end
      S_ST: begin
        state_d     = S_DONE;
        rsp_rdata_d = '0;
        rsp_fault_d = 1'b0;
      end
      S_RMW_RD: begin
        state_d = S_RMW_WR;
        merge_d = mem_rdata;
      end
      S_RMW_WR: begin
        state_d     = S_DONE;
        rsp_rdata_d = '0;
        rsp_fault_d = 1'b0;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rsp_valid_d = (state_d == S_DONE);
  end

  // Reset aborts any operation in flight; the memory enables are decoded from
  // state, so no partial write can leak out once the state is forced to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      merge_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      merge_q     <= merge_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    mem_read  = (state_q == S_LD) || (state_q == S_RMW_RD);
    mem_write = (state_q == S_ST) || (state_q == S_RMW_WR);
    mem_addr  = (mem_read || mem_write) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata = '0;
    if (state_q == S_ST) begin
      mem_wdata = wdata_q;
    end else if (state_q == S_RMW_WR) begin
      mem_wdata = st_word;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw: a small word memory model plus per-request
// cycle tracking of memory enables and the response pulse.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_rmw #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  assign mem_rdata = mem_read ? mem[mem_addr[5:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // e_rd / e_wr / e_rsp: cycle after the accept edge where the event is
  // expected (0 = never).
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int e_rd, input int e_wr, input int e_rsp,
                         input logic [31:0] e_maddr, input logic [31:0] e_wdata,
                         input logic [31:0] e_rdata, input logic e_fault);
    int rd_c = 0, wr_c = 0, rsp_c = 0, n_rd = 0, n_wr = 0, n_rsp = 0;
    int both = 0, rdy_bad = 0;
    logic [31:0] rd_a = 0, wr_a = 0, wr_d = 0, r_d = 0;
    logic r_f = 0;
    @(negedge clk);
    chk({tag, ".ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
      end
      if (mem_read && mem_write) both++;
      if (mem_read) begin n_rd++; rd_c = c; rd_a = mem_addr; end
      if (mem_write) begin n_wr++; wr_c = c; wr_a = mem_addr; wr_d = mem_wdata; end
      if (rsp_valid) begin n_rsp++; rsp_c = c; r_d = rsp_rdata; r_f = rsp_fault; end
      if (req_ready != (c > e_rsp)) rdy_bad++;
    end
    chk({tag, ".rd_cyc"}, rd_c, e_rd);
    chk({tag, ".n_rd"}, n_rd, (e_rd != 0) ? 1 : 0);
    if (e_rd != 0) chk({tag, ".rd_addr"}, rd_a, e_maddr);
    chk({tag, ".wr_cyc"}, wr_c, e_wr);
    chk({tag, ".n_wr"}, n_wr, (e_wr != 0) ? 1 : 0);
    if (e_wr != 0) begin
      chk({tag, ".wr_addr"}, wr_a, e_maddr);
      chk({tag, ".wr_data"}, wr_d, e_wdata);
    end
    chk({tag, ".rsp_cyc"}, rsp_c, e_rsp);
    chk({tag, ".n_rsp"}, n_rsp, 1);
    chk({tag, ".rdata"}, r_d, e_rdata);
    chk({tag, ".fault"}, r_f, e_fault);
    chk({tag, ".rd_wr_overlap"}, both, 0);
    chk({tag, ".ready_busy"}, rdy_bad, 0);
  endtask

  initial begin
    int n_wr_rst, n_rsp_rst;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", req_ready, 1);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_rdata", rsp_rdata, 0);
    chk("rst.rsp_fault", rsp_fault, 0);
    chk("rst.mem_read", mem_read, 0);
    chk("rst.mem_write", mem_write, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    // Loads
    preload(4'd4, 32'h8765_4321);
    run_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 1, 0, 2, 32'h10, 32'h0, 32'h8765_4321, 1'b0);
    preload(4'd4, 32'h80FF_0102);
    run_req("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 1, 0, 2, 32'h10, 32'h0, 32'hFFFF_FF80, 1'b0);
    run_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 1, 0, 2, 32'h10, 32'h0, 32'h0000_0080, 1'b0);
    run_req("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 1, 0, 2, 32'h10, 32'h0, 32'hFFFF_80FF, 1'b0);
    run_req("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 1, 0, 2, 32'h10, 32'h0, 32'h0000_80FF, 1'b0);
    run_req("lb11", 1'b0, 3'b000, 32'h11, 32'h0, 1, 0, 2, 32'h10, 32'h0, 32'h0000_0001, 1'b0);

    // Stores
    preload(4'd8, 32'h1122_3344);
    run_req("sb21", 1'b1, 3'b000, 32'h21, 32'h5555_55AB, 1, 2, 3, 32'h20, 32'h1122_AB44, 32'h0, 1'b0);
    chk("sb21.mem", mem[8], 32'h1122_AB44);
    preload(4'd8, 32'h1122_3344);
    run_req("sh22", 1'b1, 3'b001, 32'h22, 32'h7777_BEEF, 1, 2, 3, 32'h20, 32'hBEEF_3344, 32'h0, 1'b0);
    chk("sh22.mem", mem[8], 32'hBEEF_3344);
    run_req("sh20", 1'b1, 3'b001, 32'h20, 32'h0000_1234, 1, 2, 3, 32'h20, 32'hBEEF_1234, 32'h0, 1'b0);
    run_req("sw24", 1'b1, 3'b010, 32'h24, 32'hCAFE_F00D, 0, 1, 2, 32'h24, 32'hCAFE_F00D, 32'h0, 1'b0);
    chk("sw24.mem", mem[9], 32'hCAFE_F00D);

    // Faults: no memory access, response one cycle after accept
    run_req("f_lw11", 1'b0, 3'b010, 32'h11, 32'h0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 1'b1);
    run_req("f_sh23", 1'b1, 3'b001, 32'h23, 32'hFFFF, 0, 0, 1, 32'h0, 32'h0, 32'h0, 1'b1);
    run_req("f_ld011", 1'b0, 3'b011, 32'h10, 32'h0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 1'b1);
    run_req("f_sbu", 1'b1, 3'b100, 32'h20, 32'h0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("fault.mem8_kept", mem[8], 32'hBEEF_1234);

    // Reset during the read half of an SB
    preload(4'd8, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'hAB;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid.in_rmw_rd", mem_read, 1);
    rst_n = 1'b0;
    n_wr_rst = 0; n_rsp_rst = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (mem_write) n_wr_rst++;
      if (rsp_valid) n_rsp_rst++;
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_write) n_wr_rst++;
      if (rsp_valid) n_rsp_rst++;
    end
    chk("rstmid.no_write", n_wr_rst, 0);
    chk("rstmid.no_rsp", n_rsp_rst, 0);
    chk("rstmid.req_ready", req_ready, 1);
    chk("rstmid.mem_read", mem_read, 0);
    chk("rstmid.mem_addr", mem_addr, 0);
    chk("rstmid.rsp_rdata", rsp_rdata, 0);
    chk("rstmid.rsp_fault", rsp_fault, 0);
    chk("rstmid.mem8", mem[8], 32'h1122_3344);

    // Unit is usable again after the abort
    run_req("post_lw", 1'b0, 3'b010, 32'h20, 32'h0, 1, 0, 2, 32'h20, 32'h0, 32'h1122_3344, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
